// File: rtl/aes_seq_ctrl_pkg.sv
// Shared types and constants for the AES sequencing controller.
// Holds the controller state encoding, the custom opcode and the round counts per key size.
package aes_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      ROUND,
      FINAL,
      WB
   } aes_state_e;

   localparam logic [6:0] AES_OPCODE = 7'b0001011;

   localparam int unsigned AES128_ROUNDS = 10;
   localparam int unsigned AES192_ROUNDS = 12;
   localparam int unsigned AES256_ROUNDS = 14;

   // Width of a round index that must hold 0..rounds inclusive.
   function automatic int unsigned round_idx_width(input int unsigned rounds);
      return $clog2(rounds + 1);
   endfunction

endpackage

// File: rtl/aes_seq_ctrl_if.sv
// Issue, datapath-control, writeback and perf signals of the AES sequencer.
// master = sequencer side, slave = pipeline/datapath side.
interface aes_seq_ctrl_if #(
   parameter int unsigned NUM_ROUNDS = 10,
   parameter int unsigned RD_W       = 5
);
   localparam int unsigned IDX_W = $clog2(NUM_ROUNDS + 1);

   logic             issue_valid;
   logic             issue_dec;
   logic [RD_W-1:0]  issue_rd;
   logic             flush;
   logic             aes_done;
   logic             dp_load;
   logic             dp_round_en;
   logic             dp_final;
   logic [IDX_W-1:0] dp_round_idx;
   logic             dp_dec;
   logic             key_exp_en;
   logic             wb_valid;
   logic [RD_W-1:0]  wb_rd;
   logic             wb_ready;
   logic [31:0]      perf_ops;
   logic [31:0]      perf_busy;

   modport master (
      input  issue_valid, issue_dec, issue_rd, flush, wb_ready,
      output aes_done, dp_load, dp_round_en, dp_final, dp_round_idx, dp_dec,
             key_exp_en, wb_valid, wb_rd, perf_ops, perf_busy
   );

   modport slave (
      output issue_valid, issue_dec, issue_rd, flush, wb_ready,
      input  aes_done, dp_load, dp_round_en, dp_final, dp_round_idx, dp_dec,
             key_exp_en, wb_valid, wb_rd, perf_ops, perf_busy
   );

endinterface

// File: rtl/aes_seq_ctrl_perf.sv
// Completed-operation and busy-cycle counters for the AES sequencer.
// Both counters wrap modulo 2^32.
module aes_seq_perf (
   input  logic        clk,
   input  logic        nrst,
   input  logic        busy,
   input  logic        done,
   output logic [31:0] ops,
   output logic [31:0] busy_cycles
);

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         ops         <= '0;
         busy_cycles <= '0;
      end else begin
         if (done) ops <= ops + 32'd1;
         if (busy) busy_cycles <= busy_cycles + 32'd1;
      end
   end

endmodule

// File: rtl/aes_seq_ctrl.sv
// Sequencing FSM for the multi-cycle AES coprocessor: load, rounds, final round, writeback.
// Optional perf counters are built when AES_SEQ_CTRL_PERF_EN is defined.
module aes_seq_ctrl
   import aes_ctrl_pkg::*;
#(
   parameter int unsigned NUM_ROUNDS = AES128_ROUNDS,
   parameter int unsigned RD_W       = 5
) (
   input  logic           clk,
   input  logic           nrst,
   aes_seq_ctrl_if.master bus
);

   localparam int unsigned       IDX_W    = round_idx_width(NUM_ROUNDS);
   localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
   localparam logic [IDX_W-1:0]  IDX_MID  = IDX_W'(NUM_ROUNDS - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_ROUNDS);

   if (NUM_ROUNDS < 2 || NUM_ROUNDS > 14) begin : g_bad_rounds
      $error("aes_seq_ctrl: NUM_ROUNDS must be in 2..14");
   end

   aes_state_e       state_q, state_d;
   logic [IDX_W-1:0] round_q, round_d;
   logic             dec_q, dec_d;
   logic [RD_W-1:0]  rd_q, rd_d;

   logic load, round_en, final_en, key_exp, wb_valid;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= IDLE;
         round_q <= '0;
         dec_q   <= 1'b0;
         rd_q    <= '0;
      end else begin
         state_q <= state_d;
         round_q <= round_d;
         dec_q   <= dec_d;
         rd_q    <= rd_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      round_d  = round_q;
      dec_d    = dec_q;
      rd_d     = rd_q;
      load     = 1'b0;
      round_en = 1'b0;
      final_en = 1'b0;
      key_exp  = 1'b0;
      wb_valid = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (bus.issue_valid && !bus.flush) begin
               state_d = LOAD;
               round_d = '0;
               dec_d   = bus.issue_dec;
               rd_d    = bus.issue_rd;
            end
         end
         LOAD: begin
            load = 1'b1;
            if (bus.flush) begin
               state_d = IDLE;
               round_d = '0;
            end else begin
               state_d = ROUND;
               round_d = IDX_ONE;
            end
         end
         ROUND: begin
            round_en = 1'b1;
            key_exp  = 1'b1;
            if (bus.flush) begin
               state_d = IDLE;
               round_d = '0;
            end else if (round_q >= IDX_MID) begin
               // Saturating compare keeps the index from ever passing NUM_ROUNDS.
               state_d = FINAL;
               round_d = IDX_LAST;
            end else begin
               round_d = round_q + IDX_ONE;
            end
         end
         FINAL: begin
            final_en = 1'b1;
            key_exp  = 1'b1;
            if (bus.flush) begin
               state_d = IDLE;
               round_d = '0;
            end else begin
               state_d = WB;
               round_d = IDX_LAST;
            end
         end
         WB: begin
            // Result is committed here, so flush is deliberately ignored.
            wb_valid = 1'b1;
            if (bus.wb_ready) begin
               state_d = IDLE;
               round_d = '0;
            end
         end
         default: begin
            state_d = IDLE;
            round_d = '0;
         end
      endcase
   end

   assign bus.aes_done     = (state_q == IDLE);
   assign bus.dp_load      = load;
   assign bus.dp_round_en  = round_en;
   assign bus.dp_final     = final_en;
   assign bus.dp_round_idx = round_q;
   assign bus.dp_dec       = dec_q;
   assign bus.key_exp_en   = key_exp;
   assign bus.wb_valid     = wb_valid;
   assign bus.wb_rd        = rd_q;

`ifdef AES_SEQ_CTRL_PERF_EN
   logic busy, done;
   assign busy = (state_q != IDLE);
   assign done = wb_valid && bus.wb_ready;

   aes_seq_perf u_perf (
      .clk         (clk),
      .nrst        (nrst),
      .busy        (busy),
      .done        (done),
      .ops         (bus.perf_ops),
      .busy_cycles (bus.perf_busy)
   );
`else
   assign bus.perf_ops  = '0;
   assign bus.perf_busy = '0;
`endif

endmodule

// File: tb/tb_aes_seq_ctrl.sv
// Directed and randomized bench for aes_seq_ctrl against a cycles-since-accept reference model.
module tb_aes_seq_ctrl;

   localparam int unsigned NR   = 10;
   localparam int unsigned RD_W = 5;

   logic clk = 1'b0;
   logic nrst;

   aes_seq_ctrl_if #(.NUM_ROUNDS(NR), .RD_W(RD_W)) bus ();

   aes_seq_ctrl #(.NUM_ROUNDS(NR), .RD_W(RD_W)) dut (
      .clk  (clk),
      .nrst (nrst),
      .bus  (bus.master)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model: an op is either absent or "age" cycles past its acceptance.
   bit              m_busy;
   int unsigned     m_age;
   logic            m_dec;
   logic [RD_W-1:0] m_rd;
   logic [31:0]     m_ops;
   logic [31:0]     m_busy_cnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_busy     = 1'b0;
      m_age      = 0;
      m_dec      = 1'b0;
      m_rd       = '0;
      m_ops      = '0;
      m_busy_cnt = '0;
   endtask

   task automatic check_outputs();
      logic        e_load, e_round, e_final, e_wb;
      int unsigned e_idx;
      logic [31:0] e_pops, e_pbusy;
      e_load  = m_busy && (m_age == 1);
      e_round = m_busy && (m_age >= 2) && (m_age <= NR);
      e_final = m_busy && (m_age == NR + 1);
      e_wb    = m_busy && (m_age >= NR + 2);
      if (!m_busy || m_age == 1) e_idx = 0;
      else if (m_age <= NR)      e_idx = m_age - 1;
      else                       e_idx = NR;
`ifdef AES_SEQ_CTRL_PERF_EN
      e_pops  = m_ops;
      e_pbusy = m_busy_cnt;
`else
      e_pops  = '0;
      e_pbusy = '0;
`endif
      chk("aes_done", 32'(bus.aes_done), 32'(!m_busy));
      chk("strobes", {29'b0, bus.dp_load, bus.dp_round_en, bus.dp_final},
          {29'b0, e_load, e_round, e_final});
      chk("key_exp_en", 32'(bus.key_exp_en), 32'(e_round | e_final));
      chk("round_idx", 32'(bus.dp_round_idx), e_idx);
      chk("wb_valid", 32'(bus.wb_valid), 32'(e_wb));
      chk("wb_rd", 32'(bus.wb_rd), 32'(m_rd));
      chk("dp_dec", 32'(bus.dp_dec), 32'(m_dec));
      chk("perf_ops", bus.perf_ops, e_pops);
      chk("perf_busy", bus.perf_busy, e_pbusy);
   endtask

   task automatic model_adv(input logic iv, input logic dec, input logic [RD_W-1:0] rd,
                            input logic fl, input logic wr);
      if (!m_busy) begin
         if (iv && !fl) begin
            m_busy = 1'b1;
            m_age  = 1;
            m_dec  = dec;
            m_rd   = rd;
         end
      end else begin
         m_busy_cnt = m_busy_cnt + 32'd1;
         if (m_age >= NR + 2) begin
            if (wr) begin
               m_busy = 1'b0;
               m_ops  = m_ops + 32'd1;
            end
         end else if (fl) begin
            m_busy = 1'b0;
         end else begin
            m_age++;
         end
      end
   endtask

   // Called at posedge+1: apply inputs, check current outputs, advance model, cross one edge.
   task automatic step(input logic iv, input logic dec, input logic [RD_W-1:0] rd,
                       input logic fl, input logic wr);
      bus.issue_valid = iv;
      bus.issue_dec   = dec;
      bus.issue_rd    = rd;
      bus.flush       = fl;
      bus.wb_ready    = wr;
      check_outputs();
      model_adv(iv, dec, rd, fl, wr);
      @(posedge clk);
      #1;
   endtask

   initial begin
      nrst            = 1'b0;
      bus.issue_valid = 1'b0;
      bus.issue_dec   = 1'b0;
      bus.issue_rd    = '0;
      bus.flush       = 1'b0;
      bus.wb_ready    = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_outputs();
      @(negedge clk);
      nrst = 1'b1;
      @(posedge clk);
      #1;

      // Plain encrypt, wb_ready always high.
      step(1'b1, 1'b0, 5'd7, 1'b0, 1'b1);
      repeat (14) step(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);

      // Writeback backpressure: ready held low for the first 4 WB cycles.
      step(1'b1, 1'b0, 5'd7, 1'b0, 1'b0);
      for (int i = 1; i <= 18; i++) step(1'b0, 1'b0, 5'd0, 1'b0, (i >= 16));

      // Flush during ROUND at idx 4, then a normal op to rd 3.
      step(1'b1, 1'b1, 5'd21, 1'b0, 1'b1);
      repeat (4) step(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
      chk("idx_before_flush", 32'(bus.dp_round_idx), 32'd4);
      step(1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
      repeat (3) step(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 5'd3, 1'b0, 1'b1);
      repeat (14) step(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);

      // issue_valid together with flush in IDLE is dropped.
      step(1'b1, 1'b1, 5'd9, 1'b1, 1'b1);
      repeat (2) step(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);

      // Asynchronous reset in the middle of FINAL.
      step(1'b1, 1'b1, 5'd17, 1'b0, 1'b1);
      repeat (10) step(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
      check_outputs();
      #2;
      nrst = 1'b0;
      #1;
      model_reset();
      check_outputs();
      @(negedge clk);
      nrst = 1'b1;
      @(posedge clk);
      #1;

      // Back-to-back: second request held while the first is busy.
      step(1'b1, 1'b0, 5'd5, 1'b0, 1'b1);
      repeat (20) step(1'b1, 1'b1, 5'd12, 1'b0, 1'b1);
      repeat (14) step(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);

      // Randomized traffic with occasional flushes and writeback stalls.
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 3) == 0), 1'($urandom), RD_W'($urandom),
              ($urandom_range(0, 15) == 0), 1'($urandom));
      end
      repeat (20) step(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/aes_seq_ctrl.md
Name: aes_seq_ctrl

Overview:
- Sequencing controller for the multi-cycle AES coprocessor datapath (custom opcode 0001011).
- Accepts one AES instruction from issue and steps the datapath through load, round and final stages.
- Drives aes_done to the data-hazard scoreboard so later AES instructions stall while the unit is busy.
- Arbitrates the result onto the register-file writeback port with a valid/ready handshake; aborts cleanly on pipeline flush.

Parameters:
- NUM_ROUNDS, 10, number of AES rounds (10/12/14 for AES-128/192/256); legal range 2..14.
- RD_W, 5, destination register index width.

Ports:
- clk  in  1  clock, rising edge
- nrst  in  1  asynchronous active-low reset
- issue_valid  in  1  AES instruction present in issue stage
- issue_dec  in  1  1 = decrypt, 0 = encrypt
- issue_rd  in  RD_W  destination register
- flush  in  1  pipeline kill/exception flush
- aes_done  out  1  unit idle and able to accept; feeds scoreboard
- dp_load  out  1  datapath loads state/key operands
- dp_round_en  out  1  datapath performs one middle round
- dp_final  out  1  datapath performs final round (no MixColumns)
- dp_round_idx  out  $clog2(NUM_ROUNDS+1)  current round number
- dp_dec  out  1  latched direction for datapath
- key_exp_en  out  1  key schedule advances one step
- wb_valid  out  1  result ready for writeback
- wb_rd  out  RD_W  latched destination register
- wb_ready  in  1  writeback port granted this cycle
- perf_ops  out  32  completed-operation count (optional feature)
- perf_busy  out  32  non-idle cycle count (optional feature)

Behaviour:
- States: IDLE, LOAD, ROUND, FINAL, WB. Reset (async, any state) -> IDLE, round counter 0, all outputs 0 except aes_done=1.
- aes_done = (state==IDLE), combinational from state only.
- Accept: issue_valid & aes_done & !flush. Latches issue_dec -> dp_dec and issue_rd -> wb_rd. IDLE->LOAD. Acceptance with flush high is dropped.
- LOAD (1 cycle): dp_load=1, dp_round_idx=0 -> ROUND.
- ROUND: dp_round_en=1, key_exp_en=1, idx runs 1..NUM_ROUNDS-1, incrementing each cycle. Leave for FINAL when idx==NUM_ROUNDS-1.
- FINAL (1 cycle): dp_final=1, key_exp_en=1, idx=NUM_ROUNDS -> WB.
- WB: wb_valid=1 held with wb_rd stable until wb_ready. On wb_valid&wb_ready -> IDLE, idx cleared.
- Latency: accept at cycle 0 gives earliest wb_valid at cycle NUM_ROUNDS+2 (12 for default).
- Datapath strobes (dp_load, dp_round_en, dp_final) are mutually exclusive; at most one high per cycle.
- flush in LOAD/ROUND/FINAL: next state IDLE, no wb_valid, counters cleared; strobes drop the following cycle.
- flush in WB is ignored; the result is already architecturally committed.
- flush in IDLE has no effect apart from blocking acceptance.
- A new acceptance is impossible in the cycle WB completes because aes_done is still 0. The earliest next accept is the following cycle.
- Round counter saturates and never wraps past NUM_ROUNDS.

Optional Feature:
- Macro AES_SEQ_CTRL_PERF_EN.
- Defined: perf_ops increments on each wb_valid&wb_ready; perf_busy increments every cycle state!=IDLE. Both are 32-bit, wrap modulo 2^32, reset to 0, and are unaffected by flush except that flushed cycles still count as busy.
- Undefined: both ports present and tied to 0; no counter flops.

Decomposition:
- Package aes_ctrl_pkg: state enum (IDLE, LOAD, ROUND, FINAL, WB), AES opcode constant 7'b0001011, round counts per key size (AES128_ROUNDS=10, AES192_ROUNDS=12, AES256_ROUNDS=14).
- Sub-module aes_seq_perf holds the two counters and is instantiated only under AES_SEQ_CTRL_PERF_EN. FSM and round counter stay in the top module.

Test Plan:
- Encrypt, NUM_ROUNDS=10, wb_ready tied 1, issue_rd=7 at cycle 0 -> aes_done low at cycle 1. dp_load at cycle 1, dp_round_en cycles 2-10 with idx 1..9, dp_final cycle 11 idx 10, wb_valid cycle 12 with wb_rd=7, aes_done high cycle 13.
- Writeback backpressure: wb_ready low for 4 cycles after wb_valid -> wb_valid and wb_rd=7 held stable 5 cycles; single completion; perf_ops +1 when enabled.
- flush during ROUND at idx=4 -> IDLE next cycle, no wb_valid ever, aes_done=1. A subsequent issue_valid with issue_rd=3 accepted and completes normally.
- issue_valid and flush both high in IDLE -> not accepted, dp_load stays 0, aes_done stays 1.
- nrst asserted mid-FINAL -> all strobes and wb_valid 0 immediately, aes_done=1, perf counters 0.
- Back-to-back: second issue_valid held high while busy -> accepted the cycle after first WB handshake; dp_dec follows the second op's issue_dec=1.
